// File: rtl/mmio_timer.sv
// mmio_timer: bus-mapped programmable timer with level interrupt.
// Four word registers (CTRL, COUNT, CMP, STATUS) in a 16-byte window at
// BASE_ADDR. Reads are combinational; writes commit on the rising edge.
// Optional build macro: MMIO_TIMER_PRESCALER_EN adds a divide-by-PRESCALE
// tick prescaler; without it the counter ticks every cycle while enabled.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0F00,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        DMWr,
  input  logic        DMRd,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [2:0]  DMType,
  output logic [31:0] dout,
  output logic        timer_int,
  input  logic        timer_int_ack
);

  // Register offsets within the window (word index from addr[3:2]).
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_COUNT  = 2'd1;
  localparam logic [1:0] OFF_CMP    = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  // CTRL bit positions.
  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;
  localparam int CTRL_IE = 2;

  // Architectural state.
  logic [2:0]  ctrl_q,  ctrl_d;
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q,   cmp_d;
  logic        pend_q,  pend_d;

  // Bus decode.
  logic       sel;
  logic [1:0] offset;
  logic       wr_word;
  logic       wr_ctrl;
  logic       wr_count;
  logic       wr_cmp;
  logic       wr_status;

  // Timer datapath helpers.
  logic en;
  logic ar;
  logic ie;
  logic tick;
  logic match;

  // The byte-lane bits of the address carry no meaning for word registers.
  logic unused_bits;
  assign unused_bits = ^addr[1:0];

  assign sel    = (addr[31:4] == BASE_ADDR[31:4]);
  assign offset = addr[3:2];

  // Only full-word writes change state; sub-word stores are dropped.
  assign wr_word   = DMWr & sel & (DMType == 3'b000);
  assign wr_ctrl   = wr_word & (offset == OFF_CTRL);
  assign wr_count  = wr_word & (offset == OFF_COUNT);
  assign wr_cmp    = wr_word & (offset == OFF_CMP);
  assign wr_status = wr_word & (offset == OFF_STATUS);

  assign en = ctrl_q[CTRL_EN];
  assign ar = ctrl_q[CTRL_AR];
  assign ie = ctrl_q[CTRL_IE];

`ifdef MMIO_TIMER_PRESCALER_EN
  // Last prescaler value before a tick is issued.
  localparam logic [31:0] PRESCALE_LAST = PRESCALE - 1;

  logic [31:0] presc_q, presc_d;

  // Prescaler next state: restarts on CTRL/COUNT writes, advances only while enabled.
  always_comb begin
    presc_d = presc_q;
    if (wr_ctrl || wr_count) begin
      presc_d = 32'h0;
    end else if (en) begin
      if (presc_q == PRESCALE_LAST) begin
        presc_d = 32'h0;
      end else begin
        presc_d = presc_q + 32'h1;
      end
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q <= 32'h0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick = en & (presc_q == PRESCALE_LAST);
`else
  // Divider not built: PRESCALE has no effect in this configuration.
  localparam int unsigned prescale_unused = PRESCALE;

  assign tick = en;
`endif

  // A match is only an event when the counter actually ticks.
  assign match = tick & (count_q == cmp_q);

  // COUNT next state: a bus write overrides whatever the tick would do.
  always_comb begin
    count_d = count_q;
    if (wr_count) begin
      count_d = din;
    end else if (tick) begin
      if (match) begin
        // Auto-reload restarts from zero; one-shot parks on the compare value.
        count_d = ar ? 32'h0 : count_q;
      end else begin
        // Natural 32-bit wrap; reaching zero this way is not an event.
        count_d = count_q + 32'h1;
      end
    end
  end

  // CTRL next state: software write wins over the one-shot self-disable.
  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ctrl) begin
      ctrl_d = din[2:0];
    end else if (match && !ar) begin
      ctrl_d[CTRL_EN] = 1'b0;
    end
  end

  // CMP next state: plain read/write register.
  always_comb begin
    cmp_d = cmp_q;
    if (wr_cmp) begin
      cmp_d = din;
    end
  end

  // PEND next state: a fresh match is never lost to a simultaneous clear.
  always_comb begin
    pend_d = pend_q;
    if (match) begin
      pend_d = 1'b1;
    end else if (timer_int_ack || (wr_status && din[0])) begin
      pend_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_q  <= 3'b000;
      count_q <= 32'h0;
      cmp_q   <= 32'hFFFF_FFFF;
      pend_q  <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      pend_q  <= pend_d;
    end
  end

  // Read mux: zero unless a read strobe hits the window; shows pre-write values.
  always_comb begin
    dout = 32'h0;
    if (DMRd && sel) begin
      case (offset)
        OFF_CTRL:   dout = {29'h0, ctrl_q};
        OFF_COUNT:  dout = count_q;
        OFF_CMP:    dout = cmp_q;
        OFF_STATUS: dout = {31'h0, pend_q};
        default:    dout = 32'h0;
      endcase
    end
  end

  assign timer_int = pend_q & ie;

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: table of bus vectors plus hand-written
// timing sequences; read data checked through an expected-value queue.
module tb_mmio_timer;

  localparam logic [31:0] B = 32'h0000_0F00;
`ifdef MMIO_TIMER_PRESCALER_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic        clk;
  logic        rstn;
  logic        DMWr;
  logic        DMRd;
  logic [31:0] addr;
  logic [31:0] din;
  logic [2:0]  DMType;
  logic [31:0] dout;
  logic        timer_int;
  logic        timer_int_ack;

  mmio_timer #(.BASE_ADDR(B), .PRESCALE(4)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .DMWr         (DMWr),
    .DMRd         (DMRd),
    .addr         (addr),
    .din          (din),
    .DMType       (DMType),
    .dout         (dout),
    .timer_int    (timer_int),
    .timer_int_ack(timer_int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  ty;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end else begin
      $display("ok   %s = %h", nm, act);
    end
  endtask

  // One bus cycle: drive, sample read data at negedge, commit at posedge.
  task automatic bus_op(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] ty,
                        input bit chk, input logic [31:0] exp, input string nm);
    logic [31:0] e;
    string       n;
    DMWr = wr; DMRd = rd; addr = a; din = wd; DMType = ty;
    if (chk) begin
      exp_q.push_back(exp);
      name_q.push_back(nm);
    end
    @(negedge clk);
    if (chk) begin
      if (exp_q.size() == 0) begin
        check({nm, "_queue_empty"}, 32'h1, 32'h0);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, dout, e);
      end
    end
    @(posedge clk);
    #1;
    DMWr = 1'b0; DMRd = 1'b0; DMType = 3'b000;
  endtask

  task automatic wr_reg(input logic [31:0] off, input logic [31:0] data);
    bus_op(1'b1, 1'b0, B + off, data, 3'b000, 1'b0, 32'h0, "wr");
  endtask

  task automatic rd_reg(input logic [31:0] off, input logic [31:0] exp, input string nm);
    bus_op(1'b0, 1'b1, B + off, 32'h0, 3'b000, 1'b1, exp, nm);
  endtask

  // Cycles from the current write edge until timer_int is seen, bounded.
  task automatic wait_int(output int n);
    n = 0;
    while (!timer_int && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    int ticks;
    logic [31:0] exp_int;

    tbl[0]  = '{1'b1, 1'b0, B + 32'h8,  32'h1234_5678, 3'b000, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, B + 32'h8,  32'h0,         3'b000, 1'b1, 32'h1234_5678};
    tbl[2]  = '{1'b1, 1'b0, B + 32'h8,  32'hDEAD_BEEF, 3'b001, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, B + 32'h8,  32'h0000_CAFE, 3'b010, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 1'b1, B + 32'h8,  32'h0,         3'b000, 1'b1, 32'h1234_5678};
    tbl[5]  = '{1'b1, 1'b0, B + 32'h4,  32'h0000_ABCD, 3'b000, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 1'b1, B + 32'h7,  32'h0,         3'b000, 1'b1, 32'h0000_ABCD};
    tbl[7]  = '{1'b1, 1'b0, B + 32'h0,  32'hFFFF_FFFA, 3'b000, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, B + 32'h0,  32'h0,         3'b000, 1'b1, 32'h2};
    tbl[9]  = '{1'b0, 1'b1, B + 32'h10, 32'h0,         3'b000, 1'b1, 32'h0};
    tbl[10] = '{1'b0, 1'b0, B + 32'h4,  32'h0,         3'b000, 1'b1, 32'h0};
    tbl[11] = '{1'b1, 1'b1, B + 32'h8,  32'h0000_0055, 3'b000, 1'b1, 32'h1234_5678};
    tbl[12] = '{1'b0, 1'b1, B + 32'h8,  32'h0,         3'b001, 1'b1, 32'h0000_0055};
    tbl[13] = '{1'b1, 1'b0, 32'h0000_1F08, 32'h99,     3'b000, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 1'b1, B + 32'h8,  32'h0,         3'b000, 1'b1, 32'h0000_0055};
    tbl[15] = '{1'b1, 1'b0, B + 32'h0,  32'h0,         3'b000, 1'b0, 32'h0};
    tbl[16] = '{1'b0, 1'b1, B + 32'h0,  32'h0,         3'b000, 1'b1, 32'h0};
    tbl[17] = '{1'b0, 1'b1, B + 32'hC,  32'h0,         3'b000, 1'b1, 32'h0};

    rstn = 1'b0; DMWr = 1'b0; DMRd = 1'b0; addr = 32'h0; din = 32'h0;
    DMType = 3'b000; timer_int_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Reset applied while the counter is running.
    wr_reg(32'h8, 32'd100);
    wr_reg(32'h0, 32'h1);
    repeat (10) @(posedge clk);
    #1 rstn = 1'b0;
    rd_reg(32'h0, 32'h0,         "rst_ctrl");
    rd_reg(32'h4, 32'h0,         "rst_count");
    rd_reg(32'h8, 32'hFFFF_FFFF, "rst_cmp");
    rd_reg(32'hC, 32'h0,         "rst_status");
    check("rst_timer_int", {31'h0, timer_int}, 32'h0);
    check("rst_dout_idle", dout, 32'h0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven register and bus-rule vectors.
    for (int i = 0; i < 18; i++) begin
      bus_op(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].wd, tbl[i].ty,
             tbl[i].chk, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // One-shot with interrupt enabled.
    wr_reg(32'h4, 32'h0);
    wr_reg(32'h8, 32'd5);
    wr_reg(32'h0, 32'h5);
    wait_int(n);
    check("oneshot_latency", n, 6 * PS);
    rd_reg(32'h0, 32'h4, "oneshot_ctrl");
    rd_reg(32'h4, 32'h5, "oneshot_count");
    rd_reg(32'hC, 32'h1, "oneshot_status");
    timer_int_ack = 1'b1;
    @(negedge clk);
    check("ack_cycle_int", {31'h0, timer_int}, 32'h1);
    @(posedge clk);
    #1 timer_int_ack = 1'b0;
    check("ack_int_drop", {31'h0, timer_int}, 32'h0);

    // One-shot with interrupt masked, then STATUS write-1-to-clear.
    wr_reg(32'h4, 32'h0);
    wr_reg(32'h8, 32'd2);
    wr_reg(32'h0, 32'h1);
    repeat (3 * PS + 2) @(posedge clk);
    #1;
    check("masked_int", {31'h0, timer_int}, 32'h0);
    rd_reg(32'hC, 32'h1, "masked_status");
    wr_reg(32'hC, 32'h0);
    rd_reg(32'hC, 32'h1, "w0c_status");
    wr_reg(32'hC, 32'h1);
    rd_reg(32'hC, 32'h0, "w1c_status");
    wr_reg(32'h0, 32'h4);

    // Auto-reload: acks at first two events, ack/match collision later,
    // and a W1C/match collision after that.
    wr_reg(32'h4, 32'h0);
    wr_reg(32'h8, 32'd3);
    wr_reg(32'h0, 32'h7);
    for (int k = 0; k <= 20 * PS + 1; k++) begin
      exp_int = ((k == 4 * PS) || (k == 8 * PS) || (k >= 12 * PS)) ? 32'h1 : 32'h0;
      check($sformatf("ar_int_k%0d", k), {31'h0, timer_int}, exp_int);
      timer_int_ack = (k == 4 * PS) || (k == 8 * PS) || (k == 16 * PS - 1);
      if (k == 20 * PS - 1) begin
        bus_op(1'b1, 1'b0, B + 32'hC, 32'h1, 3'b000, 1'b0, 32'h0, "w1c_collide");
      end else begin
        bus_op(1'b0, 1'b1, B + 32'h4, 32'h0, 3'b000, 1'b1,
               32'((k / PS) % 4), $sformatf("ar_count_k%0d", k));
      end
      timer_int_ack = 1'b0;
    end

    // COUNT write while ticking, then freeze by clearing EN.
    wr_reg(32'h4, 32'h100);
    rd_reg(32'h4, 32'h100, "count_wr_wins");
    wr_reg(32'h0, 32'h0);
    ticks = 0;
    for (int j = 1; j <= 2; j++) if (j % PS == 0) ticks++;
    rd_reg(32'h4, 32'h100 + 32'(ticks), "count_frozen_a");
    rd_reg(32'h4, 32'h100 + 32'(ticks), "count_frozen_b");
    rd_reg(32'hC, 32'h1, "pend_kept_on_disable");
    wr_reg(32'hC, 32'h1);
    rd_reg(32'hC, 32'h0, "pend_cleared");

    // Prescaler latency (3 cycles built without the divider, 12 with it).
    wr_reg(32'h4, 32'h0);
    wr_reg(32'h8, 32'd2);
    wr_reg(32'h0, 32'h5);
    wait_int(n);
    check("prescale_latency", n, 3 * PS);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped timer peripheral that responds to CPU load/store accesses on the data-memory bus and raises a level interrupt toward the CPU. It sits beside the data memory on the same bus (CPU initiator → this block as responder) and drives the CPU's `timer_int` input, clearing it on the CPU's `timer_int_ack`. Used instead of the free-running fixed-limit timer when software must program period, mode and enable.

## Interface
- `BASE_ADDR`, 32'h0000_0F00, word-aligned base of the 16-byte register window
- `PRESCALE`, 1, cycles per counter tick (≥1); used only with the prescaler compiled in

- `clk` input 1: sole clock, rising edge
- `rstn` input 1: reset, asynchronous, active-low
- `DMWr` input 1: bus write strobe
- `DMRd` input 1: bus read strobe
- `addr` input 32: full byte address
- `din` input 32: write data
- `DMType` input 3: access size; 3'b000 = word, all other codes are sub-word
- `dout` output 32: read data
- `timer_int` output 1: interrupt request, level
- `timer_int_ack` input 1: CPU acknowledge, one-cycle pulse

## Operation
- Select: `sel = (addr[31:4] == BASE_ADDR[31:4])`; offset = `addr[3:2]`; `addr[1:0]` ignored.
- Registers:
  - 0x0 CTRL [2:0]: bit0 EN (count enable), bit1 AR (auto-reload), bit2 IE (interrupt enable); upper bits read 0.
  - 0x4 COUNT [31:0]: current count, read/write.
  - 0x8 CMP [31:0]: compare value, read/write.
  - 0xC STATUS [0]: PEND; write 1 to clear, write 0 no effect.
- Writes: taken on `clk` rising edge when `DMWr & sel & DMType==3'b000`; sub-word writes ignored entirely (no register change).
- Reads: `dout` = selected register when `DMRd & sel`, else 32'h0. DMType does not affect reads.
- Tick: with EN=1, one tick per cycle (or per PRESCALE cycles, see Configuration).
- On tick: if COUNT == CMP → PEND←1; then AR=1 → COUNT←0, AR=0 → COUNT holds, EN←0 (one-shot). Else COUNT←COUNT+1, wrapping 32'hFFFF_FFFF→0 without setting PEND.
- `timer_int` = PEND & IE (registered PEND, combinational AND).
- `timer_int_ack` high → PEND←0.
- Priorities in the same cycle:
  - CPU write to COUNT beats tick update; write to CTRL beats one-shot EN clear.
  - Match set beats ack and beats STATUS W1C (event not lost).
  - `DMWr` and `DMRd` both high: read returns pre-write value; write applies at edge.
- EN cleared by software: COUNT and prescaler freeze, PEND untouched.

## Timing
- Reset (async, `rstn` low): CTRL=0, COUNT=0, CMP=32'hFFFF_FFFF, PEND=0, prescaler=0; `timer_int`=0, `dout`=0 (no read strobe). Reset mid-count aborts immediately; first tick earliest on the second rising edge after `rstn` rises.
- Read latency 0: `dout` combinational from registers in the access cycle, matching dm read timing.
- Write latency 1: value visible on reads the cycle after the write edge.
- Match: with CMP=N, EN set at edge t0 with COUNT=0 and prescale 1, PEND rises at edge t0+N+1; `timer_int` high in the same cycle if IE=1.
- Ack: `timer_int` drops the cycle after the edge sampling `timer_int_ack`.
- Period in auto-reload: (CMP+1)×PRESCALE cycles.

## Configuration
- `MMIO_TIMER_PRESCALER_EN` defined: internal prescaler counter 0..PRESCALE-1 advances while EN=1; tick when it equals PRESCALE-1, then wraps to 0. Write to CTRL or COUNT resets prescaler to 0.
- Undefined: no prescaler logic; tick every cycle while EN=1; PRESCALE ignored.

## Test plan
- Reset: hold `rstn`=0 mid-count, read all four offsets → CTRL 0, COUNT 0, CMP 0xFFFF_FFFF, STATUS 0; `timer_int`=0.
- One-shot: CMP=5, CTRL=0x5 → `timer_int` rises 6 cycles after CTRL write edge; CTRL reads 0x4, COUNT holds 5; pulse ack → `timer_int` 0 next cycle.
- Auto-reload: CMP=3, CTRL=0x7, ack every interrupt → `timer_int` rises every 4 cycles, COUNT sequence 0,1,2,3,0.
- Collisions: ack and match in same cycle → PEND stays 1; write COUNT=0x100 during active tick → COUNT reads 0x100.
- Bus rules: byte write (DMType≠0) to CMP → CMP unchanged; read at BASE_ADDR+0x10 → `dout` 0; STATUS write 0 → PEND unchanged, write 1 → cleared.
- Prescaler (macro defined, PRESCALE=4): CMP=2, CTRL=0x5 → `timer_int` after 12 cycles; without macro, same setup → 3 cycles.
